// File: rtl/regfile_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// regfile_access_ctrl_if
//
// Purpose:
//   Bundles the decode/writeback-side signals of regfile_access_ctrl: the
//   read request/response handshake and the write request.
//
// Signals:
//   req_valid / req_ready      read request handshake
//   src_reg1 / src_reg2        read indices for port 1 / port 2
//   rsp_valid / rsp_ready      read response handshake
//   rsp_data1 / rsp_data2      read results
//   wr_en / wr_reg / wr_data   write request (always accepted)
//
// Modports:
//   master  the requester (decode/writeback logic)
//   slave   the access controller
// ----------------------------------------------------------------------------
interface regfile_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 16
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] src_reg1;
    logic [ADDR_W-1:0] src_reg2;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data1;
    logic [WIDTH-1:0]  rsp_data2;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [WIDTH-1:0]  wr_data;

    modport master (
        output req_valid, src_reg1, src_reg2, rsp_ready, wr_en, wr_reg, wr_data,
        input  req_ready, rsp_valid, rsp_data1, rsp_data2
    );

    modport slave (
        input  req_valid, src_reg1, src_reg2, rsp_ready, wr_en, wr_reg, wr_data,
        output req_ready, rsp_valid, rsp_data1, rsp_data2
    );

endinterface

// File: rtl/regfile_access_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_access_ctrl
//
// Purpose:
//   Read/write sequencer for the bitline register file. Converts register
//   indices into one-hot strobes for the Register array, drives the shared
//   write-data bus D, samples the array bitlines during a read and returns
//   the data over a valid/ready handshake.
//
// Parameters:
//   NREG    number of registers / one-hot strobe width (NREG <= 2**ADDR_W)
//   ADDR_W  register index width
//   WIDTH   data / bitline width
//
// Ports:
//   clk                         system clock, rising edge
//   rst                         synchronous, active-high reset
//   bus (slave modport)         read request/response and write request
//   WriteReg      out  NREG     one-hot write strobe to the array
//   D             out  WIDTH    write-data bus to the array
//   ReadEnable1/2 out  NREG     one-hot read strobes, non-zero only in DRIVE
//   Bitline1/2    in   WIDTH    array bitlines, sampled only at end of DRIVE
//
// Read sequence (3 cycles minimum):
//   IDLE  -> accept request, latch one-hot enables
//   DRIVE -> enables on the array, bitlines captured at the closing edge
//   RESP  -> rsp_valid held with stable data until rsp_ready
//
// Write sequence:
//   wr_en registered once; WriteReg/D present for exactly one cycle after it,
//   the array captures at the end of that cycle. Back-to-back writes allowed.
//
// An index >= NREG yields an all-zero strobe: such a write is dropped and
// such a read returns 0.
//
// Optional feature (compile-time macro RF_BYPASS_EN):
//   When defined, a read whose DRIVE cycle coincides with a WriteReg strobe
//   to the same register captures D instead of the bitline on that port, so
//   the response carries the new value. When undefined the bitline is always
//   captured (old value) and no comparison logic exists.
// ----------------------------------------------------------------------------
module regfile_access_ctrl #(
    parameter int NREG   = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    regfile_access_ctrl_if.slave  bus,

    output logic [NREG-1:0]       WriteReg,
    output logic [WIDTH-1:0]      D,
    output logic [NREG-1:0]       ReadEnable1,
    output logic [NREG-1:0]       ReadEnable2,
    input  logic [WIDTH-1:0]      Bitline1,
    input  logic [WIDTH-1:0]      Bitline2
);

    // ------------------------------------------------------------------
    // Index decode. Indices outside 0..NREG-1 match no bit, so they give
    // an all-zero strobe with no separate range check.
    // ------------------------------------------------------------------
    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == ADDR_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // ------------------------------------------------------------------
    // Write path: one register stage, independent of the read FSM.
    // ------------------------------------------------------------------
    logic [NREG-1:0]  write_reg_d, write_reg_q;
    logic [WIDTH-1:0] d_d, d_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no
        // path leaves it unassigned and no latch is inferred.
        write_reg_d = '0;
        d_d         = d_q;          // D holds its last value between writes
        if (bus.wr_en) begin
            write_reg_d = onehot(bus.wr_reg);
            d_d         = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // A write registered but not yet strobed is cancelled here.
            write_reg_q <= '0;
            d_q         <= '0;
        end else begin
            write_reg_q <= write_reg_d;
            d_q         <= d_d;
        end
    end

    assign WriteReg = write_reg_q;
    assign D        = d_q;

    // ------------------------------------------------------------------
    // Read capture values, evaluated in the DRIVE cycle. A port with an
    // all-zero enable (out-of-range index) returns 0; its bitline is not
    // driven by the array and must not be trusted.
    // ------------------------------------------------------------------
    logic [NREG-1:0]  re1_q, re2_q;
    logic [WIDTH-1:0] cap1, cap2;

    always_comb begin
        cap1 = (|re1_q) ? Bitline1 : '0;
        cap2 = (|re2_q) ? Bitline2 : '0;
`ifdef RF_BYPASS_EN
        // Both vectors are one-hot over valid registers, so any overlap means
        // the strobed write targets the register being read this cycle. The
        // array has not captured it yet, so forward D instead of the bitline.
        if (|(re1_q & write_reg_q)) begin
            cap1 = d_q;
        end
        if (|(re2_q & write_reg_q)) begin
            cap2 = d_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Read FSM with registered outputs.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } rd_state_e;

    rd_state_e        state_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data1_q, rsp_data2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Any response in flight is discarded.
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            re1_q       <= '0;
            re2_q       <= '0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        // Enables are precomputed so they are clean flop
                        // outputs for the whole DRIVE cycle.
                        re1_q       <= onehot(bus.src_reg1);
                        re2_q       <= onehot(bus.src_reg2);
                        req_ready_q <= 1'b0;
                        state_q     <= DRIVE;
                    end
                end

                DRIVE: begin
                    re1_q       <= '0;
                    re2_q       <= '0;
                    rsp_data1_q <= cap1;
                    rsp_data2_q <= cap2;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end

                RESP: begin
                    // Data registers are untouched here, so the response
                    // stays stable for as long as the consumer stalls.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    re1_q       <= '0;
                    re2_q       <= '0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // The ready flop resets to 1 (IDLE can accept), but requests are not
    // accepted while rst is high, so the requester must see 0 then.
    assign bus.req_ready = req_ready_q & ~rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data1 = rsp_data1_q;
    assign bus.rsp_data2 = rsp_data2_q;

    assign ReadEnable1   = re1_q;
    assign ReadEnable2   = re2_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_access_ctrl
//
// Directed bench for regfile_access_ctrl (NREG=8, ADDR_W=4, WIDTH=16).
// A behavioural register array answers the read strobes on the bitlines and
// captures D on WriteReg. Each issued read pushes its hand-computed response
// into a queue; a monitor compares every cycle rsp_valid is high and pops on
// the handshake. Strobe timing and reset behaviour are checked inline.
// ----------------------------------------------------------------------------
module tb_regfile_access_ctrl;

    localparam int NREG   = 8;
    localparam int ADDR_W = 4;
    localparam int WIDTH  = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_access_ctrl_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus_if ();

    logic [NREG-1:0]  write_reg;
    logic [WIDTH-1:0] d_bus;
    logic [NREG-1:0]  read_en1, read_en2;
    logic [WIDTH-1:0] bitline1, bitline2;

    regfile_access_ctrl #(
        .NREG   (NREG),
        .ADDR_W (ADDR_W),
        .WIDTH  (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .WriteReg    (write_reg),
        .D           (d_bus),
        .ReadEnable1 (read_en1),
        .ReadEnable2 (read_en2),
        .Bitline1    (bitline1),
        .Bitline2    (bitline2)
    );

    // ------------------------------------------------------------------
    // Behavioural register array (not reset by rst; cleared by arr_clear)
    // ------------------------------------------------------------------
    logic             arr_clear;
    logic [WIDTH-1:0] regs [NREG];

    always @(posedge clk) begin
        if (arr_clear) begin
            for (int i = 0; i < NREG; i++) regs[i] <= WIDTH'(32'hA000 + i);
        end else begin
            for (int i = 0; i < NREG; i++) if (write_reg[i]) regs[i] <= d_bus;
        end
    end

    always_comb begin
        bitline1 = 'z;
        bitline2 = 'z;
        for (int i = 0; i < NREG; i++) begin
            if (read_en1[i]) bitline1 = regs[i];
            if (read_en2[i]) bitline2 = regs[i];
        end
    end

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_rsp    = 0;

    typedef struct {
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] exp_oh(input int idx);
        logic [NREG-1:0] v;
        v = '0;
        if (idx < NREG) v[idx] = 1'b1;
        return v;
    endfunction

    // Response monitor: data must match the queued expectation every cycle
    // rsp_valid is high (stability under backpressure), pop on handshake.
    always @(negedge clk) begin
        if (!rst && bus_if.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                check("rsp_data1", bus_if.rsp_data1, exp_q[0].d1);
                check("rsp_data2", bus_if.rsp_data2, exp_q[0].d2);
                if (bus_if.rsp_ready) begin
                    void'(exp_q.pop_front());
                    n_rsp++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "simulation timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: drive just after posedge, sample on negedge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_write(input int r, input logic [WIDTH-1:0] v);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_reg  = ADDR_W'(r);
        bus_if.wr_data = v;
        tick();
        bus_if.wr_en   = 1'b0;
        at_neg();
        check("wr_strobe", write_reg, exp_oh(r));
        check("wr_dbus", d_bus, v);
    endtask

    // Read with rsp_ready held high: accept, DRIVE, RESP, back to IDLE.
    task automatic do_read(input int s1, input int s2,
                           input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2);
        check("rd_req_ready_idle", bus_if.req_ready, 1'b1);
        bus_if.req_valid = 1'b1;
        bus_if.src_reg1  = ADDR_W'(s1);
        bus_if.src_reg2  = ADDR_W'(s2);
        bus_if.rsp_ready = 1'b1;
        exp_q.push_back('{d1: e1, d2: e2});
        tick();
        bus_if.req_valid = 1'b0;
        at_neg();
        check("rd_re1_drive", read_en1, exp_oh(s1));
        check("rd_re2_drive", read_en2, exp_oh(s2));
        check("rd_req_ready_busy", bus_if.req_ready, 1'b0);
        tick();
        at_neg();
        check("rd_rsp_valid", bus_if.rsp_valid, 1'b1);
        check("rd_re1_off", read_en1, '0);
        tick();
        at_neg();
        check("rd_rsp_done", bus_if.rsp_valid, 1'b0);
        check("rd_req_ready_back", bus_if.req_ready, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst              = 1'b1;
        arr_clear        = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.src_reg1  = '0;
        bus_if.src_reg2  = '0;
        bus_if.rsp_ready = 1'b0;
        bus_if.wr_en     = 1'b0;
        bus_if.wr_reg    = '0;
        bus_if.wr_data   = '0;

        // Reset state
        repeat (3) tick();
        at_neg();
        check("rst_req_ready", bus_if.req_ready, 1'b0);
        check("rst_rsp_valid", bus_if.rsp_valid, 1'b0);
        check("rst_rsp_data1", bus_if.rsp_data1, '0);
        check("rst_rsp_data2", bus_if.rsp_data2, '0);
        check("rst_write_reg", write_reg, '0);
        check("rst_d", d_bus, '0);
        check("rst_re1", read_en1, '0);
        check("rst_re2", read_en2, '0);
        rst       = 1'b0;
        arr_clear = 1'b0;
        tick();

        // Write R3 = 0x1234: strobe for exactly one cycle, D then holds
        do_write(3, 16'h1234);
        tick();
        at_neg();
        check("wr_strobe_single", write_reg, '0);
        check("wr_d_hold", d_bus, 16'h1234);

        // Same index on both ports after the write has landed
        do_read(3, 3, 16'h1234, 16'h1234);

        // Back-to-back writes R0, R1, R2
        bus_if.wr_en = 1'b1; bus_if.wr_reg = 4'd0; bus_if.wr_data = 16'h1111;
        tick();
        bus_if.wr_reg = 4'd1; bus_if.wr_data = 16'h2222;
        at_neg();
        check("b2b_strobe0", write_reg, 8'h01);
        tick();
        bus_if.wr_reg = 4'd2; bus_if.wr_data = 16'h3333;
        at_neg();
        check("b2b_strobe1", write_reg, 8'h02);
        check("b2b_d1", d_bus, 16'h2222);
        tick();
        bus_if.wr_en = 1'b0;
        at_neg();
        check("b2b_strobe2", write_reg, 8'h04);
        tick();
        do_read(0, 1, 16'h1111, 16'h2222);

        // Read R5 = 0xBEEF with 4 cycles of backpressure
        do_write(5, 16'hBEEF);
        tick();
        bus_if.req_valid = 1'b1;
        bus_if.src_reg1  = 4'd5;
        bus_if.src_reg2  = 4'd5;
        bus_if.rsp_ready = 1'b0;
        exp_q.push_back('{d1: 16'hBEEF, d2: 16'hBEEF});
        tick();
        bus_if.req_valid = 1'b0;
        at_neg();
        for (int i = 0; i < 4; i++) begin
            tick();
            at_neg();
            check("bp_rsp_valid", bus_if.rsp_valid, 1'b1);
            check("bp_req_ready", bus_if.req_ready, 1'b0);
        end
        bus_if.rsp_ready = 1'b1;
        tick();
        at_neg();
        check("bp_rsp_done", bus_if.rsp_valid, 1'b0);
        check("bp_req_ready_back", bus_if.req_ready, 1'b1);

        // Hazard: write R7 and read R7 accepted in the same cycle, so the
        // strobe coincides with DRIVE. Port 2 reads R5 and is unaffected.
        do_write(7, 16'h0001);
        tick();
        bus_if.wr_en     = 1'b1;
        bus_if.wr_reg    = 4'd7;
        bus_if.wr_data   = 16'hAAAA;
        bus_if.req_valid = 1'b1;
        bus_if.src_reg1  = 4'd7;
        bus_if.src_reg2  = 4'd5;
        bus_if.rsp_ready = 1'b1;
`ifdef RF_BYPASS_EN
        exp_q.push_back('{d1: 16'hAAAA, d2: 16'hBEEF});
`else
        exp_q.push_back('{d1: 16'h0001, d2: 16'hBEEF});
`endif
        tick();
        bus_if.wr_en     = 1'b0;
        bus_if.req_valid = 1'b0;
        at_neg();
        check("hz_strobe", write_reg, 8'h80);
        check("hz_re1", read_en1, 8'h80);
        tick();
        at_neg();
        check("hz_rsp_valid", bus_if.rsp_valid, 1'b1);
        tick();
        at_neg();
        check("hz_rsp_done", bus_if.rsp_valid, 1'b0);

        // Reset during DRIVE with a write to R7 just registered
        bus_if.req_valid = 1'b1;
        bus_if.src_reg1  = 4'd7;
        bus_if.src_reg2  = 4'd7;
        exp_q.push_back('{d1: 16'hAAAA, d2: 16'hAAAA});
        tick();
        bus_if.req_valid = 1'b0;
        rst              = 1'b1;
        bus_if.wr_en     = 1'b1;
        bus_if.wr_reg    = 4'd7;
        bus_if.wr_data   = 16'h5555;
        exp_q.delete();
        tick();
        rst          = 1'b0;
        bus_if.wr_en = 1'b0;
        at_neg();
        check("mr_rsp_valid", bus_if.rsp_valid, 1'b0);
        check("mr_write_reg", write_reg, '0);
        check("mr_req_ready", bus_if.req_ready, 1'b1);
        check("mr_re1", read_en1, '0);
        tick();
        do_read(7, 7, 16'hAAAA, 16'hAAAA);

        // Out-of-range index: write dropped, read returns 0
        do_write(9, 16'h7777);
        tick();
        do_read(9, 2, 16'h0000, 16'h3333);

        tick();
        check("end_queue_empty", exp_q.size(), 0);
        check("end_rsp_count", n_rsp, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
